// File: rtl/treasury_pkg.sv
// Shared encodings for the treasury job dispatcher: result status codes,
// dispatcher FSM state type and default header/nonce widths.
package treasury_pkg;

  localparam int HDR_W_DEFAULT   = 640;
  localparam int NONCE_W_DEFAULT = 32;

  localparam logic [1:0] ST_FOUND     = 2'b00;
  localparam logic [1:0] ST_EXHAUSTED = 2'b01;
  localparam logic [1:0] ST_TIMEOUT   = 2'b10;
  localparam logic [1:0] ST_ABORTED   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/treasury_job_timer.sv
// RUN-cycle counter for the job dispatcher; cleared in LAUNCH, counts while
// running and flags expiry in the cycle where count == TIMEOUT_CYCLES-1.
module treasury_job_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = run && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/treasury_job_dispatcher.sv
// Issues one header job at a time to the treasury hashing array and returns a
// tagged result. Build macro TREASURY_JOB_TIMEOUT_EN adds the RUN timeout.
module treasury_job_dispatcher
  import treasury_pkg::*;
#(
  parameter int HDR_W   = HDR_W_DEFAULT,
  parameter int NONCE_W = NONCE_W_DEFAULT,
  parameter int ID_W    = 8
`ifdef TREASURY_JOB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [HDR_W-1:0]   job_header,
  input  logic [ID_W-1:0]    job_id,
  input  logic               cancel,
  output logic [HDR_W-1:0]   arr_header,
  output logic               arr_start,
  output logic               arr_abort,
  input  logic               arr_success,
  input  logic [NONCE_W-1:0] arr_nonce,
  input  logic               arr_exhausted,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ID_W-1:0]    res_id,
  output logic [NONCE_W-1:0] res_nonce,
  output logic [1:0]         res_status,
  output logic               busy,
  output logic [15:0]        jobs_done,
  output logic [1:0]         fsm_state
);

  state_t     state, state_next;
  logic       timeout_hit;
  logic       run_exit;
  logic       run_abort;
  logic [1:0] run_status;

`ifdef TREASURY_JOB_TIMEOUT_EN
  treasury_job_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == LAUNCH),
    .run     (state == RUN),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Both ports use valid/ready: a transfer happens on the rising edge where
  // valid && ready; the offering side holds its payload until then.
  assign job_ready = (state == IDLE) && !rst;
  assign res_valid = (state == REPORT);
  assign arr_start = (state == LAUNCH);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_comb begin
    state_next = state;
    run_exit   = 1'b0;
    run_abort  = 1'b0;
    run_status = ST_FOUND;
    // Exit priority: success > exhausted > cancel > timeout.
    if (arr_success) begin
      run_exit = 1'b1;
    end else if (arr_exhausted) begin
      run_exit   = 1'b1;
      run_status = ST_EXHAUSTED;
    end else if (cancel) begin
      run_exit   = 1'b1;
      run_abort  = 1'b1;
      run_status = ST_ABORTED;
    end else if (timeout_hit) begin
      run_exit   = 1'b1;
      run_abort  = 1'b1;
      run_status = ST_TIMEOUT;
    end
    case (state)
      IDLE:    if (job_valid) state_next = LAUNCH;
      LAUNCH:  state_next = RUN;
      RUN:     if (run_exit) state_next = REPORT;
      REPORT:  if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      arr_header <= '0;
      arr_abort  <= 1'b0;
      res_id     <= '0;
      res_nonce  <= '0;
      res_status <= ST_FOUND;
      jobs_done  <= '0;
    end else begin
      state     <= state_next;
      arr_abort <= 1'b0;
      if (state == IDLE && job_valid) begin
        arr_header <= job_header;
        res_id     <= job_id;
      end
      if (state == RUN && run_exit) begin
        res_nonce  <= arr_success ? arr_nonce : '0;
        res_status <= run_status;
        arr_abort  <= run_abort;
      end
      if (state == REPORT && res_ready) begin
        jobs_done <= jobs_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_treasury_job_dispatcher.sv
// Directed bench for treasury_job_dispatcher: vector table of single-job
// scenarios plus hand sequences for backpressure, timeout, reset and wrap.
module tb_treasury_job_dispatcher;

  localparam int HDR_W   = 640;
  localparam int NONCE_W = 32;
  localparam int ID_W    = 8;
  localparam int RES_W   = ID_W + NONCE_W + 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               job_valid;
  logic               job_ready;
  logic [HDR_W-1:0]   job_header;
  logic [ID_W-1:0]    job_id;
  logic               cancel;
  logic [HDR_W-1:0]   arr_header;
  logic               arr_start;
  logic               arr_abort;
  logic               arr_success;
  logic [NONCE_W-1:0] arr_nonce;
  logic               arr_exhausted;
  logic               res_valid;
  logic               res_ready;
  logic [ID_W-1:0]    res_id;
  logic [NONCE_W-1:0] res_nonce;
  logic [1:0]         res_status;
  logic               busy;
  logic [15:0]        jobs_done;
  logic [1:0]         fsm_state;

  treasury_job_dispatcher #(
    .HDR_W(HDR_W), .NONCE_W(NONCE_W), .ID_W(ID_W)
`ifdef TREASURY_JOB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_header(job_header), .job_id(job_id), .cancel(cancel),
    .arr_header(arr_header), .arr_start(arr_start), .arr_abort(arr_abort),
    .arr_success(arr_success), .arr_nonce(arr_nonce), .arr_exhausted(arr_exhausted),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_nonce(res_nonce), .res_status(res_status), .busy(busy),
    .jobs_done(jobs_done), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int abort_cnt = 0;
  logic [15:0] exp_done;
  logic [RES_W-1:0] exp_q[$];

  always @(posedge clk) begin
    if (arr_start) start_cnt++;
    if (arr_abort) abort_cnt++;
  end

  typedef struct {
    logic [7:0]  id;
    int          wait_cycles;
    logic        success;
    logic        exhausted;
    logic        cxl;
    logic [31:0] nonce;
    logic [1:0]  exp_status;
    logic [31:0] exp_nonce;
    logic        exp_abort;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [HDR_W-1:0] make_hdr(input logic [7:0] id);
    logic [31:0] word;
    word = {4{id}} ^ 32'h5A5A_C3C3;
    return {20{word}};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_job(input logic [7:0] id);
    int s0;
    job_id     = id;
    job_header = make_hdr(id);
    job_valid  = 1'b1;
    s0 = start_cnt;
    check("job_ready_before_accept", job_ready, 1);
    tick();
    job_valid = 1'b0;
    check("arr_start_launch", arr_start, 1);
    check("arr_header_match", (arr_header === make_hdr(id)), 1);
    tick();
    check("arr_start_once", start_cnt - s0, 1);
    check("arr_start_low_in_run", arr_start, 0);
  endtask

  // Called in the first REPORT cycle (or later); finishes with the handshake.
  task automatic check_result(input logic exp_abort);
    logic [RES_W-1:0] exp;
    int a0;
    a0 = abort_cnt;
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
      return;
    end
    exp = exp_q.pop_front();
    check("res_valid", res_valid, 1);
    check("res_id", res_id, exp[RES_W-1 -: ID_W]);
    check("res_nonce", res_nonce, exp[NONCE_W+1:2]);
    check("res_status", res_status, exp[1:0]);
    check("arr_abort_pulse", arr_abort, exp_abort);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_done = exp_done + 16'd1;
    check("arr_abort_count", abort_cnt - a0, exp_abort);
    check("arr_abort_cleared", arr_abort, 0);
    check("jobs_done", jobs_done, exp_done);
    check("job_ready_after_result", job_ready, 1);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    start_job(v.id);
    repeat (v.wait_cycles) tick();
    check("busy_in_run", busy, 1);
    check("res_valid_in_run", res_valid, 0);
    arr_success   = v.success;
    arr_exhausted = v.exhausted;
    cancel        = v.cxl;
    arr_nonce     = v.nonce;
    exp_q.push_back({v.id, v.exp_nonce, v.exp_status});
    tick();
    arr_success   = 1'b0;
    arr_exhausted = 1'b0;
    cancel        = 1'b0;
    arr_nonce     = 32'hDEAD_0000;
    check_result(v.exp_abort);
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{8'h05, 3, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0};
    vecs[1] = '{8'h11, 0, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D, 2'b00, 32'hCAFE_F00D, 1'b0};
    vecs[2] = '{8'h22, 2, 1'b0, 1'b1, 1'b0, 32'hAAAA_5555, 2'b01, 32'h0000_0000, 1'b0};
    vecs[3] = '{8'h33, 1, 1'b0, 1'b0, 1'b1, 32'h7777_7777, 2'b11, 32'h0000_0000, 1'b1};
    vecs[4] = '{8'h44, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0001, 2'b01, 32'h0000_0000, 1'b0};
    vecs[5] = '{8'hFF, 4, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 2'b00, 32'hFFFF_FFFE, 1'b0};

    rst = 1'b1;
    job_valid = 1'b0; job_header = '0; job_id = '0; cancel = 1'b0;
    arr_success = 1'b0; arr_nonce = '0; arr_exhausted = 1'b0; res_ready = 1'b0;
    exp_done = 16'd0;
    repeat (3) tick();

    // Reset state
    check("rst_job_ready", job_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_arr_start", arr_start, 0);
    check("rst_arr_abort", arr_abort, 0);
    check("rst_arr_header_zero", (arr_header === '0), 1);
    check("rst_res_id", res_id, 0);
    check("rst_res_nonce", res_nonce, 0);
    check("rst_res_status", res_status, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_fsm_state", fsm_state, 0);
    rst = 1'b0;
    #1;
    check("job_ready_out_of_reset", job_ready, 1);

    // RUN-only inputs are ignored in IDLE
    begin
      int a0;
      a0 = abort_cnt;
      cancel = 1'b1; arr_success = 1'b1; arr_exhausted = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick();
        check("idle_ignore_busy", busy, 0);
        check("idle_ignore_res_valid", res_valid, 0);
      end
      cancel = 1'b0; arr_success = 1'b0; arr_exhausted = 1'b0;
      check("idle_ignore_no_abort", abort_cnt - a0, 0);
    end

    // Table-driven single-job scenarios
    for (int i = 0; i < 6; i++) run_vec(i);

    // Result backpressure: outputs hold, second job waits for IDLE
    start_job(8'h66);
    arr_success = 1'b1; arr_nonce = 32'h0BAD_F00D;
    exp_q.push_back({8'h66, 32'h0BAD_F00D, 2'b00});
    tick();
    arr_success = 1'b0; arr_nonce = '0;
    job_id = 8'h77; job_header = make_hdr(8'h77); job_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("bp_res_valid", res_valid, 1);
      check("bp_res_id", res_id, 8'h66);
      check("bp_res_nonce", res_nonce, 32'h0BAD_F00D);
      check("bp_res_status", res_status, 2'b00);
      check("bp_job_ready", job_ready, 0);
      check("bp_arr_header_held", (arr_header === make_hdr(8'h66)), 1);
      tick();
    end
    check_result(1'b0);
    start_job(8'h77);
    cancel = 1'b1;
    exp_q.push_back({8'h77, 32'h0, 2'b11});
    tick();
    cancel = 1'b0;
    check_result(1'b1);

    // Timeout / no-timeout build
`ifdef TREASURY_JOB_TIMEOUT_EN
    begin
      int cyc;
      start_job(8'h88);
      cyc = 2;
      while (!res_valid && cyc < 60) begin
        tick();
        cyc++;
      end
      check("timeout_latency", cyc, 18);
      exp_q.push_back({8'h88, 32'h0, 2'b10});
      check_result(1'b1);
    end
`else
    start_job(8'h88);
    repeat (1000) tick();
    check("no_timeout_busy", busy, 1);
    check("no_timeout_res_valid", res_valid, 0);
    cancel = 1'b1;
    exp_q.push_back({8'h88, 32'h0, 2'b11});
    tick();
    cancel = 1'b0;
    check_result(1'b1);
`endif

    // Reset in the middle of RUN
    begin
      int a0;
      start_job(8'h99);
      tick();
      a0 = abort_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_done = 16'd0;
      check("midrst_busy", busy, 0);
      check("midrst_res_valid", res_valid, 0);
      check("midrst_arr_start", arr_start, 0);
      check("midrst_arr_abort", arr_abort, 0);
      check("midrst_arr_header_zero", (arr_header === '0), 1);
      check("midrst_res_id", res_id, 0);
      check("midrst_res_status", res_status, 0);
      check("midrst_jobs_done", jobs_done, 0);
      tick();
      check("midrst_no_abort", abort_cnt - a0, 0);
      run_vec(2);
    end

    // jobs_done wrap from 0xFFFF
    force dut.jobs_done = 16'hFFFF;
    #2;
    release dut.jobs_done;
    exp_done = 16'hFFFF;
    tick();
    check("wrap_preload", jobs_done, 16'hFFFF);
    run_vec(0);
    check("wrap_zero", jobs_done, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
